// File: rtl/dma_pkg.sv
// Shared types for the DMA priority arbiter: FSM states, channel index type
// and the channel-count constant.
package dma_pkg;

  localparam int NUM_CHANNELS = 4;

  typedef logic [1:0] channel_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_REQ = 2'd1,
    GRANT    = 2'd2,
    RELEASE  = 2'd3
  } dma_state_t;

  function automatic logic [NUM_CHANNELS-1:0] chan_onehot(input channel_t ch);
    logic [NUM_CHANNELS-1:0] oh;
    oh = '0;
    oh[ch] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/dma_rotate_encoder.sv
// Combinational winner selection: fixed order (channel 0 first) or rotating
// order starting at ptr.
module dma_rotate_encoder
  import dma_pkg::*;
(
  input  logic [NUM_CHANNELS-1:0] req,
  input  channel_t                ptr,
  input  logic                    rotate,
  output channel_t                winner,
  output logic                    any
);

  channel_t base;
  channel_t idx;

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    base   = rotate ? ptr : channel_t'(0);
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      idx = base + channel_t'(i);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: normalises requests, negotiates the bus hold with the
// CPU, grants one channel at a time and tracks the rotating priority pointer.
module dma_priority_arbiter
  import dma_pkg::*;
(
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    MasterClear,
  input  logic [NUM_CHANNELS-1:0] DREQ,
  input  logic [NUM_CHANNELS-1:0] REQUEST,
  input  logic [NUM_CHANNELS-1:0] MASK,
  input  logic                    CMD_DISABLE,
  input  logic                    CMD_ROTATE,
  input  logic                    CMD_DREQ_LOW,
  input  logic                    CMD_DACK_HIGH,
  input  logic                    HLDA,
  input  logic                    ServiceDone,
  output logic                    HRQ,
  output logic [NUM_CHANNELS-1:0] DACK,
  output logic [NUM_CHANNELS-1:0] DMA_Req,
  output channel_t                ActiveChannel,
  output logic                    ChannelValid
);

  dma_state_t              state;
  channel_t                rot_ptr;
  channel_t                winner;
  logic                    any_req;
  logic [NUM_CHANNELS-1:0] eff_req;
  logic [NUM_CHANNELS-1:0] dack_act;

  // Software requests bypass the mask; hardware requests are polarity-corrected first.
  assign eff_req = ((DREQ ^ {NUM_CHANNELS{CMD_DREQ_LOW}}) & ~MASK) | REQUEST;

  dma_rotate_encoder u_enc (
    .req    (DMA_Req),
    .ptr    (rot_ptr),
    .rotate (CMD_ROTATE),
    .winner (winner),
    .any    (any_req)
  );

  // Acknowledge is held internally active-high and inverted at the pin when needed.
  assign DACK = dack_act ^ {NUM_CHANNELS{~CMD_DACK_HIGH}};

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      DMA_Req <= '0;
    end else if (MasterClear) begin
      DMA_Req <= '0;
    end else begin
      DMA_Req <= eff_req;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      HRQ           <= 1'b0;
      dack_act      <= '0;
      ActiveChannel <= '0;
      ChannelValid  <= 1'b0;
      rot_ptr       <= '0;
    end else if (MasterClear) begin
      state         <= IDLE;
      HRQ           <= 1'b0;
      dack_act      <= '0;
      ActiveChannel <= '0;
      ChannelValid  <= 1'b0;
      rot_ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req && !CMD_DISABLE) begin
            state <= HOLD_REQ;
            HRQ   <= 1'b1;
          end
        end
        HOLD_REQ: begin
          if (!any_req || CMD_DISABLE) begin
            state <= IDLE;
            HRQ   <= 1'b0;
          end else if (HLDA) begin
            state         <= GRANT;
            ActiveChannel <= winner;
            dack_act      <= chan_onehot(winner);
            ChannelValid  <= 1'b1;
          end
        end
        GRANT: begin
          if (ServiceDone) begin
            state        <= RELEASE;
            HRQ          <= 1'b0;
            dack_act     <= '0;
            ChannelValid <= 1'b0;
            rot_ptr      <= ActiveChannel + channel_t'(1);
          end else if (!HLDA) begin
            // CPU reclaimed the bus: abandon the service without touching priority.
            state        <= IDLE;
            HRQ          <= 1'b0;
            dack_act     <= '0;
            ChannelValid <= 1'b0;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state        <= IDLE;
          HRQ          <= 1'b0;
          dack_act     <= '0;
          ChannelValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter: hand-computed grants, polarity,
// masking, abort and reset behaviour.
module tb_dma_priority_arbiter;
  import dma_pkg::*;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic       MasterClear;
  logic [3:0] DREQ;
  logic [3:0] REQUEST;
  logic [3:0] MASK;
  logic       CMD_DISABLE;
  logic       CMD_ROTATE;
  logic       CMD_DREQ_LOW;
  logic       CMD_DACK_HIGH;
  logic       HLDA;
  logic       ServiceDone;
  logic       HRQ;
  logic [3:0] DACK;
  logic [3:0] DMA_Req;
  channel_t   ActiveChannel;
  logic       ChannelValid;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLOCK = ~CLOCK;

  dma_priority_arbiter dut (
    .CLOCK         (CLOCK),
    .RESET         (RESET),
    .MasterClear   (MasterClear),
    .DREQ          (DREQ),
    .REQUEST       (REQUEST),
    .MASK          (MASK),
    .CMD_DISABLE   (CMD_DISABLE),
    .CMD_ROTATE    (CMD_ROTATE),
    .CMD_DREQ_LOW  (CMD_DREQ_LOW),
    .CMD_DACK_HIGH (CMD_DACK_HIGH),
    .HLDA          (HLDA),
    .ServiceDone   (ServiceDone),
    .HRQ           (HRQ),
    .DACK          (DACK),
    .DMA_Req       (DMA_Req),
    .ActiveChannel (ActiveChannel),
    .ChannelValid  (ChannelValid)
  );

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_hrq(input string tag);
    for (int n = 0; n < 6 && HRQ !== 1'b1; n++) tick();
    chk(tag, {7'd0, HRQ}, 8'd1);
  endtask

  task automatic clear_all();
    DREQ = CMD_DREQ_LOW ? 4'hF : 4'h0;
    REQUEST = 4'h0; HLDA = 1'b0; ServiceDone = 1'b0;
    MasterClear = 1'b1;
    tick();
    MasterClear = 1'b0;
    tick();
  endtask

  // Full hold/grant/done handshake; the request pattern must already be driven.
  task automatic serve(input string tag, input channel_t exp_ch);
    wait_hrq({tag, "_hrq"});
    HLDA = 1'b1;
    tick();
    chk({tag, "_ch"}, {6'd0, ActiveChannel}, {6'd0, exp_ch});
    chk({tag, "_dack"}, {4'd0, DACK}, {4'd0, 4'b0001 << exp_ch});
    ServiceDone = 1'b1;
    tick();
    ServiceDone = 1'b0;
    HLDA = 1'b0;
    chk({tag, "_rel"}, {6'd0, HRQ, ChannelValid}, 8'd0);
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET = 1'b1; MasterClear = 1'b0; DREQ = 4'h0; REQUEST = 4'h0; MASK = 4'h0;
    CMD_DISABLE = 1'b0; CMD_ROTATE = 1'b0; CMD_DREQ_LOW = 1'b0; CMD_DACK_HIGH = 1'b1;
    HLDA = 1'b0; ServiceDone = 1'b0;
    #1;
    chk("rst_hrq", {7'd0, HRQ}, 8'd0);
    chk("rst_dmareq", {4'd0, DMA_Req}, 8'd0);
    chk("rst_valid_ch", {5'd0, ChannelValid, ActiveChannel}, 8'd0);
    chk("rst_dack_hi", {4'd0, DACK}, 8'h00);
    CMD_DACK_HIGH = 1'b0;
    #1;
    chk("rst_dack_lo", {4'd0, DACK}, 8'h0F);
    CMD_DACK_HIGH = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    tick();

    // Fixed priority, DREQ=1010: channel 1 wins, HRQ two edges after drive
    DREQ = 4'b1010;
    tick();
    chk("fix_dmareq_k1", {4'd0, DMA_Req}, 8'h0A);
    chk("fix_hrq_k1", {7'd0, HRQ}, 8'd0);
    tick();
    chk("fix_hrq_k2", {7'd0, HRQ}, 8'd1);
    HLDA = 1'b1;
    tick();
    chk("fix_ch", {6'd0, ActiveChannel}, 8'd1);
    chk("fix_dack", {4'd0, DACK}, 8'h02);
    chk("fix_valid", {7'd0, ChannelValid}, 8'd1);
    DREQ = 4'b0001; MASK = 4'b0010;
    tick();
    chk("fix_frozen", {2'd0, ActiveChannel, DACK}, 8'h12);
    MASK = 4'h0;
    ServiceDone = 1'b1;
    tick();
    ServiceDone = 1'b0; HLDA = 1'b0;
    chk("fix_release", {3'd0, HRQ, DACK}, 8'h00);
    clear_all();

    // Rotating priority: after channel 1, order is 3, 0, 1 for DREQ=1011
    CMD_ROTATE = 1'b1;
    DREQ = 4'b0010;
    serve("rot_c1", 2'd1);
    DREQ = 4'b1011;
    serve("rot_c3", 2'd3);
    serve("rot_c0", 2'd0);
    serve("rot_c1b", 2'd1);
    clear_all();

    // Abort on channel 2: pointer stays at 0 so 1001 next goes to channel 0
    DREQ = 4'b0100;
    wait_hrq("abort_hrq");
    HLDA = 1'b1;
    tick();
    chk("abort_ch", {6'd0, ActiveChannel}, 8'd2);
    HLDA = 1'b0; DREQ = 4'b1001;
    tick();
    chk("abort_drop", {2'd0, HRQ, ChannelValid, DACK}, 8'h00);
    serve("abort_ptr", 2'd0);
    clear_all();

    // Masked DREQ never requests; software REQUEST bypasses the mask
    CMD_ROTATE = 1'b0;
    MASK = 4'b0001; DREQ = 4'b0001;
    tick(); tick(); tick();
    chk("mask_blocked", {3'd0, HRQ, DMA_Req}, 8'h00);
    REQUEST = 4'b0001;
    tick();
    chk("mask_swreq", {4'd0, DMA_Req}, 8'h01);
    tick();
    chk("mask_hrq", {7'd0, HRQ}, 8'd1);
    CMD_DISABLE = 1'b1;
    tick();
    chk("disable_hold", {7'd0, HRQ}, 8'd0);
    tick();
    chk("disable_stay", {7'd0, HRQ}, 8'd0);
    CMD_DISABLE = 1'b0; MASK = 4'h0;
    clear_all();

    // ServiceDone while idle must not disturb anything
    ServiceDone = 1'b1;
    tick();
    ServiceDone = 1'b0;
    chk("sd_idle", {2'd0, HRQ, ChannelValid, DACK}, 8'h00);

    // Inverted polarities: DREQ=1110 active-low selects channel 0
    CMD_DREQ_LOW = 1'b1; CMD_DACK_HIGH = 1'b0;
    clear_all();
    chk("inv_idle_dack", {4'd0, DACK}, 8'h0F);
    DREQ = 4'b1110;
    wait_hrq("inv_hrq");
    HLDA = 1'b1;
    tick();
    chk("inv_ch", {6'd0, ActiveChannel}, 8'd0);
    chk("inv_dack", {4'd0, DACK}, 8'h0E);

    // Asynchronous reset mid-grant, away from any clock edge
    #2;
    RESET = 1'b1;
    #1;
    chk("async_rst", {2'd0, HRQ, ChannelValid, DMA_Req}, 8'h00);
    chk("async_dack", {4'd0, DACK}, 8'h0F);
    HLDA = 1'b0;
    tick();
    RESET = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
